// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// sensor_conditioner: synchronise, debounce and hold-stretch the raw farm-road
// detector into `sensor`; optional arrival counter under SENSOR_VEHICLE_COUNT_EN.
// Revision: 1.0
// ============================================================================
module sensor_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_det,
  input  logic             clr_count,
  output logic             sensor,
  output logic             sensor_rise,
  output logic [CNT_W-1:0] car_count
);

  localparam int DEB_W  = $clog2(DEB_CYCLES) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PRESENT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   det_s;
  state_t                 state_q, state_d;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   sensor_q, sensor_d;
  logic                   rise_q, rise_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_det};
  assign det_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (det_s) begin
          deb_d   = DEB_W'(1);
          state_d = (DEB_CYCLES == 1) ? PRESENT : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!det_s) begin
          state_d = IDLE;
        end else begin
          deb_d = deb_q + DEB_W'(1);
          if (deb_d == DEB_LAST) state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (!det_s) begin
          hold_d  = HOLD_W'(1);
          state_d = (HOLD_CYCLES == 1) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (det_s) begin
          hold_d  = '0;
          state_d = PRESENT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with the state flop.
    sensor_d = (state_d == PRESENT) || (state_d == HOLD);
    rise_d   = (state_d == PRESENT) && ((state_q == IDLE) || (state_q == QUALIFY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= IDLE;
      deb_q    <= '0;
      hold_q   <= '0;
      sensor_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      sensor_q <= sensor_d;
      rise_q   <= rise_d;
    end
  end

  assign sensor      = sensor_q;
  assign sensor_rise = rise_q;

`ifdef SENSOR_VEHICLE_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Clear has priority over a same-cycle arrival.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (rise_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign car_count = count_q;
`else
  logic unused_clr_count;
  assign unused_clr_count = clr_count;
  assign car_count        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// Bench for sensor_conditioner: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and counts.
module tb_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 16;
  localparam int CW   = 2;
`ifdef SENSOR_VEHICLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          raw_det = 1'b0;
  logic          clr_count = 1'b0;
  logic          sensor, sensor_rise;
  logic [CW-1:0] car_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rise   = 0;

  sensor_conditioner #(
    .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_det(raw_det), .clr_count(clr_count),
    .sensor(sensor), .sensor_rise(sensor_rise), .car_count(car_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sensor rises once DEB consecutive synchronised highs are seen,
  // and falls once HOLD consecutive synchronised lows are seen.
  logic [SYNC-1:0] m_sync = '0;
  int m_hi = 0, m_lo = 0, m_count = 0;
  bit m_sensor = 1'b0, m_rise = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    bit d, s_n, r_n;
    int hi_n, lo_n, c_n;
    if (!rst_n) begin
      m_sync <= '0; m_hi <= 0; m_lo <= 0; m_count <= 0;
      m_sensor <= 1'b0; m_rise <= 1'b0;
    end else begin
      d    = m_sync[SYNC-1];
      hi_n = d ? m_hi + 1 : 0;
      lo_n = d ? 0 : m_lo + 1;
      s_n  = m_sensor;
      r_n  = 1'b0;
      if (!m_sensor && hi_n >= DEB) begin
        s_n = 1'b1;
        r_n = 1'b1;
      end else if (m_sensor && lo_n >= HOLD) begin
        s_n = 1'b0;
      end
      c_n = m_count;
      if (clr_count) c_n = 0;
      else if (r_n && m_count < (1 << CW) - 1) c_n = m_count + 1;
      m_sync   <= {m_sync[SYNC-2:0], raw_det};
      m_hi     <= hi_n;
      m_lo     <= lo_n;
      m_sensor <= s_n;
      m_rise   <= r_n;
      m_count  <= c_n;
    end
  end

  always @(posedge clk) begin
    #2;
    if (sensor_rise === 1'b1) n_rise++;
    check("sensor", 32'(sensor), 32'(m_sensor));
    check("sensor_rise", 32'(sensor_rise), 32'(m_rise));
    check("car_count", 32'(car_count), CNT_EN ? 32'(m_count) : 32'd0);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count rising edges until sensor reaches `level`; returns max on timeout.
  task automatic edges_until(input logic level, input int max, output int e);
    e = 0;
    while (e < max) begin
      @(posedge clk);
      e++;
      #1;
      if (sensor === level) break;
    end
    @(negedge clk);
  endtask

  task automatic vehicle(input int hi, input int lo);
    raw_det = 1'b1;
    cycles(hi);
    raw_det = 1'b0;
    cycles(lo);
  endtask

  initial begin : stim
    int e, r0;
    logic [CW-1:0] c0;

    // Reset held with detector high.
    raw_det = 1'b1;
    #1 rst_n = 1'b0;
    cycles(20);
    check("reset_sensor", 32'(sensor), 32'd0);
    check("reset_count", 32'(car_count), 32'd0);
    r0 = n_rise;
    rst_n = 1'b1;
    edges_until(1'b1, 40, e);
    check("rise_latency_after_reset", 32'(e), 32'd10);
    cycles(3);
    check("rise_pulses_after_reset", 32'(n_rise - r0), 32'd1);
    check("count_after_reset", 32'(car_count), CNT_EN ? 32'd1 : 32'd0);
    raw_det = 1'b0;
    edges_until(1'b0, 40, e);
    check("fall_latency_after_reset", 32'(e), 32'd18);
    cycles(5);

    // Glitches: 5 and DEB-1 high cycles are rejected.
    r0 = n_rise; c0 = car_count;
    vehicle(5, 30);
    vehicle(DEB - 1, 30);
    check("glitch_rise", 32'(n_rise - r0), 32'd0);
    check("glitch_count", 32'(car_count), 32'(c0));
    // Exactly DEB high cycles qualify.
    vehicle(DEB, 30);
    check("deb_boundary_rise", 32'(n_rise - r0), 32'd1);

    // Vehicle: 60 high, then low.
    r0 = n_rise;
    raw_det = 1'b1;
    edges_until(1'b1, 40, e);
    check("vehicle_rise_latency", 32'(e), 32'd10);
    cycles(50);
    raw_det = 1'b0;
    edges_until(1'b0, 40, e);
    check("vehicle_fall_latency", 32'(e), 32'd18);
    check("vehicle_rise_count", 32'(n_rise - r0), 32'd1);
    cycles(5);

    // Gap bridging: 10-cycle and HOLD-1 gaps bridged, HOLD gap is not.
    r0 = n_rise;
    vehicle(30, 10); vehicle(30, 30);
    check("gap10_rises", 32'(n_rise - r0), 32'd1);
    r0 = n_rise;
    vehicle(20, HOLD - 1); vehicle(20, 30);
    check("gap15_rises", 32'(n_rise - r0), 32'd1);
    r0 = n_rise;
    vehicle(20, HOLD); vehicle(20, 30);
    check("gap16_rises", 32'(n_rise - r0), 32'd2);

    // Saturation: counter was reset earlier, five more arrivals saturate it.
    for (int i = 0; i < 5; i++) vehicle(12, 25);
    check("saturated_count", 32'(car_count), CNT_EN ? 32'd3 : 32'd0);

    // Clear coinciding with the arrival edge of a sixth vehicle.
    raw_det = 1'b1;
    cycles(9);
    clr_count = 1'b1;
    cycles(1);
    clr_count = 1'b0;
    check("clr_rise_cycle", 32'(sensor_rise), 32'd1);
    check("clr_wins", 32'(car_count), 32'd0);

    // Mid-operation reset while in HOLD.
    cycles(10);
    raw_det = 1'b0;
    cycles(5);
    check("in_hold_sensor", 32'(sensor), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_sensor", 32'(sensor), 32'd0);
    check("async_reset_count", 32'(car_count), 32'd0);
    cycles(3);
    r0 = n_rise;
    rst_n = 1'b1;
    cycles(30);
    check("idle_after_reset", 32'(sensor), 32'd0);
    check("idle_no_rise", 32'(n_rise - r0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sensor_conditioner.md
# sensor_conditioner

Upstream front end for the `traffic_light` controller. It takes the raw, asynchronous farm-road vehicle-detector input and synchronizes it. It debounces it, then stretches it, producing the clean level `sensor` consumed directly by `traffic_light`. Optionally it also keeps a saturating count of qualified vehicle arrivals for status readout.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `raw_det`; legal values 2–3.
- `DEB_CYCLES`, default 8: consecutive high samples required to qualify a vehicle; ≥1.
- `HOLD_CYCLES`, default 16: consecutive low samples before `sensor` drops; ≥1.
- `CNT_W`, default 8: width of `car_count`.

Ports:
- `clk`, input, 1: single system clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `raw_det`, input, 1: raw detector level, asynchronous to `clk`.
- `clr_count`, input, 1: synchronous clear of `car_count`.
- `sensor`, output, 1: conditioned vehicle-present level; connects to `traffic_light` `sensor`.
- `sensor_rise`, output, 1: one-cycle pulse on each qualified arrival.
- `car_count`, output, CNT_W: saturating count of qualified arrivals.

## Operation
- `raw_det` passes through a `SYNC_STAGES`-flop chain, all reset to 0. Its output is `det_s`. No other logic samples `raw_det`.
- FSM states and transitions:
  - IDLE:
    - `sensor`=0.
    - `det_s`=1 → QUALIFY, with the debounce count set to 1.
  - QUALIFY:
    - `sensor`=0.
    - `det_s`=0 → IDLE. This is a glitch: no count, no pulse.
    - `det_s`=1 → the count increments. When the count reaches `DEB_CYCLES` → PRESENT.
  - PRESENT:
    - `sensor`=1.
    - `det_s`=0 → HOLD, with the hold count set to 1.
  - HOLD:
    - `sensor`=1.
    - `det_s`=1 → PRESENT. The hold count is discarded; this is not a new arrival and does not increment the count.
    - `det_s`=0 → the hold count increments. When it reaches `HOLD_CYCLES` → IDLE.
- `DEB_CYCLES`=1 means IDLE goes straight to PRESENT on the first high sample. `HOLD_CYCLES`=1 means PRESENT goes straight to IDLE on the first low sample.
- `sensor` and `sensor_rise` are registered and decoded from next-state.
- `sensor_rise` is 1 for exactly the cycle in which the FSM enters PRESENT from QUALIFY or IDLE.
- Debounce and hold counter widths are sized by `$clog2` of their parameter plus 1. The counters never wrap.

## Timing
- Reset values: `sensor`=0, `sensor_rise`=0, `car_count`=0. The FSM and synchronizer flops reset to IDLE and 0.
- Reset assertion forces the outputs immediately, asynchronously, from any state, including PRESENT and HOLD.
- Rising latency: if `raw_det` is stable high, `sensor` rises on the (`SYNC_STAGES`+`DEB_CYCLES`)-th rising edge after `raw_det` rises. With defaults this is the 10th edge.
- Falling latency: `sensor` falls on the (`SYNC_STAGES`+`HOLD_CYCLES`)-th edge after `raw_det` falls. With defaults this is the 18th edge.
- Low gaps on `raw_det` of up to `HOLD_CYCLES`−1 cycles are bridged: `sensor` stays 1.
- High pulses of up to `DEB_CYCLES`−1 cycles are rejected: `sensor` stays 0.
- `car_count`:
  - Increments on the same edge on which `sensor_rise` is asserted.
  - Saturates at 2^`CNT_W`−1.
  - If `clr_count` and an increment occur in the same cycle, the clear wins and the result is 0.

## Configuration
- Macro `SENSOR_VEHICLE_COUNT_EN`.
- Defined: the `car_count` register and its `clr_count` logic are built as described above.
- Undefined:
  - No counter flops are generated.
  - `car_count` is tied to 0.
  - `clr_count` is ignored.
  - `sensor` and `sensor_rise` behaviour is unchanged.

## Test plan
All scenarios use defaults (`SYNC_STAGES`=2, `DEB_CYCLES`=8, `HOLD_CYCLES`=16) unless stated.
- Reset: hold `rst_n`=0 for 20 cycles with `raw_det`=1 → `sensor`=0 and `car_count`=0 throughout. After release, `sensor` rises on the 10th edge, `sensor_rise` pulses once, and `car_count`=1.
- Glitch: drive `raw_det` high for 5 cycles, then low → `sensor` never asserts, no `sensor_rise`, `car_count` unchanged.
- Vehicle: drive `raw_det` high for 60 cycles, then low → `sensor` rises 10 edges after the rise and falls 18 edges after the fall. `car_count` increments by exactly 1.
- Gap bridging: high 30, low 10, high 30, then low → `sensor` stays continuously 1 across the gap. Only one `sensor_rise`; `car_count`+1.
- Saturation and clear: with `CNT_W`=2, send 5 qualified vehicles → `car_count`=3. Then assert `clr_count` on the `sensor_rise` cycle of a 6th vehicle → `car_count`=0.
- Mid-operation reset: assert `rst_n`=0 while in HOLD → `sensor` goes to 0 before the next edge. After release with `raw_det`=0, the block stays in IDLE.
